// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bin2bcd_state_t;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Pre-shift correction so a digit >= 5 carries into the next digit after doubling.
  function automatic logic [3:0] digit_adj(input logic [3:0] d);
    return (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit add-3 correction used by each digit slice of the converter.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d_i,
  output logic [BCD_W-1:0] d_o
);

  assign d_o = digit_adj(d_i);

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble converter with start/busy/done handshake.
// Optional leading-zero blanking output is enabled by defining BIN2BCD_SEQ_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        binary,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
`ifdef BIN2BCD_SEQ_BLANK_EN
  output logic                    overflow,
  output logic [DIGITS-1:0]       blank
`else
  output logic                    overflow
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int WRK_W = BCD_W * DIGITS;

  bin2bcd_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  op_q, op_d;
  logic [WRK_W-1:0]  work_q, work_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [WRK_W-1:0]  bcd_q, bcd_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WRK_W-1:0]  adj_s;
  logic [WRK_W:0]    shift_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (work_q[g*BCD_W +: BCD_W]),
      .d_o (adj_s[g*BCD_W +: BCD_W])
    );
  end

  // Top bit of shift_s is the bit pushed out of the most significant digit.
  assign shift_s = {adj_s, op_q[BIN_W-1]};

`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_s;
  logic              zero_run_s;

  always_comb begin
    blank_s    = '0;
    zero_run_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (shift_s[i*BCD_W +: BCD_W] == 4'd0);
      blank_s[i] = zero_run_s;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    work_d     = work_q;
    ovf_acc_d  = ovf_acc_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
`ifdef BIN2BCD_SEQ_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SHIFT;
          op_d      = binary;
          work_d    = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_acc_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        op_d      = op_q << 1;
        work_d    = shift_s[WRK_W-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        ovf_acc_d = ovf_acc_q | shift_s[WRK_W];
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          bcd_d      = shift_s[WRK_W-1:0];
          overflow_d = ovf_acc_q | shift_s[WRK_W];
`ifdef BIN2BCD_SEQ_BLANK_EN
          blank_d    = blank_s;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      work_q     <= '0;
      ovf_acc_q  <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BIN2BCD_SEQ_BLANK_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      work_q     <= work_d;
      ovf_acc_q  <= ovf_acc_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BIN2BCD_SEQ_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;
`ifdef BIN2BCD_SEQ_BLANK_EN
  assign blank    = blank_q;
`endif

endmodule
